// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch unit.
// Widths, tag/buffer bundles, FSM states and PC alignment helpers.
package fetch_pkg;

  localparam int BW_ADDRESS         = 32;
  localparam int BW_PROCESSOR_BLOCK = 64;
  localparam int BLOCK_BYTES        = BW_PROCESSOR_BLOCK / 8;
  localparam int OFF_BITS           = $clog2(BLOCK_BYTES);

  typedef logic [BW_ADDRESS-1:0]         addr_t;
  typedef logic [BW_PROCESSOR_BLOCK-1:0] block_t;

  typedef struct packed {
    addr_t pc;
    addr_t pc_next;
  } fetch_tag_t;

  typedef struct packed {
    block_t block;
    addr_t  pc;
    addr_t  pc_next;
  } fb_entry_t;

  typedef enum logic {
    RUN,
    HOLD_STALE
  } fetch_state_e;

  function automatic addr_t block_align(input addr_t a);
    return (a >> OFF_BITS) << OFF_BITS;
  endfunction

  function automatic addr_t next_block(input addr_t a);
    return block_align(a) + addr_t'(BLOCK_BYTES);
  endfunction

endpackage

// File: rtl/fetch_unit_pipelined_fifo.sv
// Register-based synchronous FIFO with flush.
// Head is read straight from storage flops.
module fetch_sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output T                           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = inc(wr_q);
      end
      if (do_pop) rd_d = inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/fetch_unit_pipelined.sv
// Pipelined I-fetch: credit-limited block requests, in-order
// responses into a fetch buffer, stale-response dropping on redirect.
module fetch_unit_pipelined
  import fetch_pkg::*;
#(
  parameter int    MAX_OUTSTANDING = 4,
  parameter int    FB_DEPTH        = 4,
  parameter addr_t RESET_PC        = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_redirect_valid,
  input  logic [BW_ADDRESS-1:0]         i_redirect_pc,
  output logic [BW_ADDRESS-1:0]         o_pred_pc,
  input  logic                          i_pred_taken,
  input  logic [BW_ADDRESS-1:0]         i_pred_target,
  output logic                          o_mem_valid,
  input  logic                          i_mem_ready,
  output logic [BW_ADDRESS-1:0]         o_mem_addr,
  input  logic                          i_mem_rvalid,
  input  logic [BW_PROCESSOR_BLOCK-1:0] i_mem_rdata,
  output logic                          o_iq_valid,
  input  logic                          i_iq_ready,
  output logic [BW_PROCESSOR_BLOCK-1:0] o_iq_block,
  output logic [BW_ADDRESS-1:0]         o_iq_pc,
  output logic [BW_ADDRESS-1:0]         o_iq_pc_next
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FW = $clog2(FB_DEPTH + 1);
  localparam int SW = ((OW > FW) ? OW : FW) + 1;

  fetch_state_e  state_q, state_d;
  addr_t         pc_q, pc_d;
  addr_t         hold_q, hold_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [OW-1:0] out_next;
  logic [OW-1:0] tag_count;
  logic [FW-1:0] fb_count;
  logic          started_q;
  logic          tag_full, tag_empty;
  logic          fb_full, fb_empty;
  fetch_tag_t    tag_in, tag_head;
  fb_entry_t     fb_in, fb_head;
  logic          credit_ok, accept, resp;
  logic          iq_pop, fb_push;
  addr_t         pc_next;

  // Outstanding count is the tag FIFO occupancy.
  assign credit_ok = !tag_full &&
    (SW'(tag_count) + SW'(fb_count) < SW'(FB_DEPTH));

  assign o_mem_valid = started_q &&
    ((state_q == HOLD_STALE) || credit_ok);
  assign o_mem_addr  = (state_q == HOLD_STALE) ?
    hold_q : block_align(pc_q);
  assign o_pred_pc   = pc_q;
  assign pc_next     = i_pred_taken ?
    i_pred_target : next_block(pc_q);

  assign accept  = o_mem_valid && i_mem_ready;
  assign resp    = i_mem_rvalid && !tag_empty;
  assign iq_pop  = !fb_empty && i_iq_ready;
  assign fb_push = resp && (drop_q == '0) &&
    !i_redirect_valid && (!fb_full || iq_pop);

  assign tag_in = '{pc: pc_q, pc_next: pc_next};
  assign fb_in  = '{block:   i_mem_rdata,
                    pc:      tag_head.pc,
                    pc_next: tag_head.pc_next};

  assign o_iq_valid   = !fb_empty;
  assign o_iq_block   = fb_head.block;
  assign o_iq_pc      = fb_head.pc;
  assign o_iq_pc_next = fb_head.pc_next;

  fetch_sync_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .T     (fetch_tag_t)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .push  (accept),
    .din   (tag_in),
    .pop   (resp),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  fetch_sync_fifo #(
    .DEPTH (FB_DEPTH),
    .T     (fb_entry_t)
  ) u_fetch_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (i_redirect_valid),
    .push  (fb_push),
    .din   (fb_in),
    .pop   (iq_pop),
    .dout  (fb_head),
    .full  (fb_full),
    .empty (fb_empty),
    .count (fb_count)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    out_next = tag_count + OW'(accept) - OW'(resp);
    drop_d   = drop_q - OW'(resp && (drop_q != '0));
    unique case (state_q)
      RUN: begin
        if (accept) pc_d = pc_next;
      end
      HOLD_STALE: begin
        if (accept) begin
          drop_d  = drop_d + 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // Everything still in flight after this edge is stale.
    if (i_redirect_valid) begin
      pc_d   = i_redirect_pc;
      drop_d = out_next;
      if (o_mem_valid && !i_mem_ready) begin
        state_d = HOLD_STALE;
        hold_d  = o_mem_addr;
      end else begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      hold_q    <= RESET_PC;
      drop_q    <= '0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      drop_q    <= drop_d;
      started_q <= 1'b1;
    end
  end

endmodule
